// File: rtl/kf_isa_pkg.sv
// rtl/kf_isa_pkg.sv - shared ISA, FSM and S9.14 constants for the Kalman filter AU sequencer
package kf_isa_pkg;

  // S9.14 sign-magnitude data format
  localparam int W    = 24;
  localparam int FRAC = 14;

  // Default sizing of the sequencer
  localparam int NREG = 16;
  localparam int PCW  = 8;
  localparam int IW   = 21;

  // Sequencer control states
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_FETCH  = 3'd1,
    ST_DECODE = 3'd2,
    ST_ISSUE  = 3'd3,
    ST_WAIT   = 3'd4
  } state_t;

  // AU operation codes
  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_MULT = 2'b10;
  localparam logic [1:0] OP_EXT  = 2'b11;

  // Instruction field positions: [20] halt, [19:18] op, [17:16] ysel,
  // [15:12] rd, [11:8] rs, [7:4] rt, [3:0] ri
  localparam int HALT_BIT = 20;
  localparam int OP_LSB   = 18;
  localparam int YSEL_LSB = 16;
  localparam int RD_LSB   = 12;
  localparam int RS_LSB   = 8;
  localparam int RT_LSB   = 4;
  localparam int RI_LSB   = 0;

endpackage

// File: rtl/kf_regfile.sv
// rtl/kf_regfile.sv - NREG x W register file, one write port (write-back over host), four read ports
module kf_regfile #(
  parameter int W    = kf_isa_pkg::W,
  parameter int NREG = kf_isa_pkg::NREG,
  localparam int RIW = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           wb_we,
  input  logic [RIW-1:0] wb_addr,
  input  logic [W-1:0]   wb_data,
  input  logic           host_we,
  input  logic [RIW-1:0] host_addr,
  input  logic [W-1:0]   host_wdata,
  input  logic [RIW-1:0] ra_rs,
  input  logic [RIW-1:0] ra_rt,
  input  logic [RIW-1:0] ra_ri,
  output logic [W-1:0]   rd_rs,
  output logic [W-1:0]   rd_rt,
  output logic [W-1:0]   rd_ri,
  output logic [W-1:0]   host_rdata
);

  logic [W-1:0] mem [NREG];

  // Single write port: AU write-back wins over a host write in the same cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        mem[i] <= '0;
      end
    end else if (wb_we) begin
      mem[wb_addr] <= wb_data;
    end else if (host_we) begin
      mem[host_addr] <= host_wdata;
    end
  end

  // Raw bit patterns are returned, so -0 reads back exactly as written
  assign rd_rs      = mem[ra_rs];
  assign rd_rt      = mem[ra_rt];
  assign rd_ri      = mem[ra_ri];
  assign host_rdata = mem[host_addr];

endmodule

// File: rtl/kf_au_sequencer.sv
// rtl/kf_au_sequencer.sv - microcode sequencer feeding the AU; AU_TIMEOUT_EN adds a WAIT timeout
module kf_au_sequencer #(
  parameter int W    = kf_isa_pkg::W,
  parameter int NREG = kf_isa_pkg::NREG,
  parameter int PCW  = kf_isa_pkg::PCW,
  parameter int IW   = kf_isa_pkg::IW,
`ifdef AU_TIMEOUT_EN
  parameter int TIMEOUT = 255,
`endif
  localparam int RIW = $clog2(NREG)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           go,
  input  logic [PCW-1:0] pc_start,
  output logic           busy,
  output logic           done,
  output logic           err,
  output logic [PCW-1:0] instr_addr,
  input  logic [IW-1:0]  instr_data,
  output logic           au_start,
  output logic [W-1:0]   au_R,
  output logic [W-1:0]   au_S,
  output logic [W-1:0]   au_Iimm,
  output logic [1:0]     au_op_sel,
  output logic [1:0]     au_mul_y_sel,
  input  logic [W-1:0]   au_result,
  input  logic           au_done,
  input  logic           host_we,
  input  logic [RIW-1:0] host_addr,
  input  logic [W-1:0]   host_wdata,
  output logic [W-1:0]   host_rdata
);

  import kf_isa_pkg::*;

  state_t         state;
  state_t         state_nx;
  logic [PCW-1:0] pc;
  logic [RIW-1:0] rd_q;
  logic           wb_we;
  logic           host_wr;
  logic [W-1:0]   rf_rs;
  logic [W-1:0]   rf_rt;
  logic [W-1:0]   rf_ri;

  // Instruction fields, meaningful while in DECODE
  logic           is_halt;
  logic [1:0]     f_op;
  logic [1:0]     f_ysel;
  logic [RIW-1:0] f_rd;
  logic [RIW-1:0] f_rs;
  logic [RIW-1:0] f_rt;
  logic [RIW-1:0] f_ri;

  assign is_halt = instr_data[HALT_BIT];
  assign f_op    = instr_data[OP_LSB +: 2];
  assign f_ysel  = instr_data[YSEL_LSB +: 2];
  assign f_rd    = instr_data[RD_LSB +: RIW];
  assign f_rs    = instr_data[RS_LSB +: RIW];
  assign f_rt    = instr_data[RT_LSB +: RIW];
  assign f_ri    = instr_data[RI_LSB +: RIW];

  assign busy    = (state != ST_IDLE);
  // The host may only touch the register file while no program runs
  assign host_wr = host_we & ~busy;

`ifdef AU_TIMEOUT_EN
  logic [7:0] tcnt;
  logic       tmo;
`endif

  kf_regfile #(.W(W), .NREG(NREG)) u_rf (
    .clk        (clk),
    .rst        (rst),
    .wb_we      (wb_we),
    .wb_addr    (rd_q),
    .wb_data    (au_result),
    .host_we    (host_wr),
    .host_addr  (host_addr),
    .host_wdata (host_wdata),
    .ra_rs      (f_rs),
    .ra_rt      (f_rt),
    .ra_ri      (f_ri),
    .rd_rs      (rf_rs),
    .rd_rt      (rf_rt),
    .rd_ri      (rf_ri),
    .host_rdata (host_rdata)
  );

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nx;
    end
  end

  // Next state plus the single-cycle strobes (done, au_start, write-back)
  always_comb begin
    state_nx = state;
    done     = 1'b0;
    au_start = 1'b0;
    wb_we    = 1'b0;
`ifdef AU_TIMEOUT_EN
    tmo      = 1'b0;
`endif
    case (state)
      ST_IDLE: begin
        if (go) state_nx = ST_FETCH;
      end
      ST_FETCH: begin
        state_nx = ST_DECODE;
      end
      ST_DECODE: begin
        if (is_halt) begin
          done     = 1'b1;
          state_nx = ST_IDLE;
        end else begin
          state_nx = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        au_start = 1'b1;
        state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        if (au_done) begin
          wb_we    = 1'b1;
          state_nx = ST_FETCH;
`ifdef AU_TIMEOUT_EN
        end else if (tcnt == 8'(TIMEOUT - 1)) begin
          tmo      = 1'b1;
          state_nx = ST_IDLE;
`endif
        end
      end
      default: begin
        state_nx = ST_IDLE;
      end
    endcase
  end

  // Program counter, ROM address and operand latches; operands hold until the next DECODE
  always_ff @(posedge clk) begin
    if (rst) begin
      pc           <= '0;
      instr_addr   <= '0;
      rd_q         <= '0;
      au_R         <= '0;
      au_S         <= '0;
      au_Iimm      <= '0;
      au_op_sel    <= '0;
      au_mul_y_sel <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (go) pc <= pc_start;
        end
        ST_FETCH: begin
          instr_addr <= pc;
        end
        ST_DECODE: begin
          if (!is_halt) begin
            au_R         <= rf_rs;
            au_S         <= rf_rt;
            au_Iimm      <= rf_ri;
            au_op_sel    <= f_op;
            au_mul_y_sel <= f_ysel;
            rd_q         <= f_rd;
          end
        end
        ST_WAIT: begin
          if (au_done) pc <= pc + 1'b1;
        end
        default: begin
        end
      endcase
    end
  end

`ifdef AU_TIMEOUT_EN
  // WAIT cycle counter and sticky timeout flag; a new go clears the flag
  always_ff @(posedge clk) begin
    if (rst) begin
      tcnt <= '0;
      err  <= 1'b0;
    end else begin
      if (state == ST_ISSUE) begin
        tcnt <= '0;
      end else if (state == ST_WAIT) begin
        tcnt <= tcnt + 8'd1;
      end
      if (state == ST_IDLE && go) begin
        err <= 1'b0;
      end else if (tmo) begin
        err <= 1'b1;
      end
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_kf_au_sequencer.sv
// tb/tb_kf_au_sequencer.sv - self-checking bench for kf_au_sequencer (AU_TIMEOUT_EN aware)
module tb_kf_au_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [7:0]  pc_start;
  logic        busy, done, err;
  logic [7:0]  instr_addr;
  logic [20:0] instr_data;
  logic        au_start;
  logic [23:0] au_R, au_S, au_Iimm;
  logic [1:0]  au_op_sel, au_mul_y_sel;
  logic [23:0] au_result;
  logic        au_done;
  logic        host_we;
  logic [3:0]  host_addr;
  logic [23:0] host_wdata, host_rdata;

  kf_au_sequencer dut (
    .clk(clk), .rst(rst), .go(go), .pc_start(pc_start), .busy(busy), .done(done),
    .err(err), .instr_addr(instr_addr), .instr_data(instr_data), .au_start(au_start),
    .au_R(au_R), .au_S(au_S), .au_Iimm(au_Iimm), .au_op_sel(au_op_sel),
    .au_mul_y_sel(au_mul_y_sel), .au_result(au_result), .au_done(au_done),
    .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_rdata(host_rdata)
  );

  always #5 clk = ~clk;

  localparam logic [20:0] HALT = 21'h100000;

  logic [20:0] rom [256];
  assign instr_data = rom[instr_addr];

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- S9.14 sign-magnitude arithmetic of the attached AU ----------------
  function automatic longint sm2i(input logic [23:0] v);
    longint m;
    m = longint'(v[22:0]);
    return v[23] ? -m : m;
  endfunction

  function automatic logic [23:0] i2sm(input longint x);
    longint m;
    logic [23:0] r;
    m = (x < 0) ? -x : x;
    if (m > 64'sh7FFFFF) m = 64'sh7FFFFF;
    r[22:0] = m[22:0];
    r[23]   = (x < 0) && (m != 0);
    return r;
  endfunction

  function automatic logic [23:0] au_func(input logic [1:0] op, input logic [23:0] r,
                                          input logic [23:0] s, input logic [23:0] i);
    case (op)
      2'b00:   return i2sm(sm2i(r) + sm2i(s));
      2'b01:   return i2sm(sm2i(r) - sm2i(s));
      2'b10:   return i2sm((sm2i(r) * sm2i(s)) / 16384);
      default: return i2sm(sm2i(r) + sm2i(i));
    endcase
  endfunction

  function automatic logic [20:0] enc(input logic [1:0] op, input logic [3:0] rd,
                                      input logic [3:0] rs, input logic [3:0] rt,
                                      input logic [3:0] ri, input logic [1:0] ysel);
    return {1'b0, op, ysel, rd, rs, rt, ri};
  endfunction

  // ---------------- AU stub and activity monitor ----------------
  typedef struct {
    logic [23:0] r, s, i;
    logic [1:0]  op, ysel;
  } iss_t;

  iss_t        iss_q[$];
  int          lat_tab [4];
  bit          stub_en;
  logic        stub_done, man_done;
  logic [23:0] stub_result, man_result;
  int          pend, stab_err;
  int          done_cnt, start_cnt, busy_cnt;
  logic [23:0] lr, ls, li;
  logic [1:0]  lop;

  assign au_done   = stub_done | man_done;
  assign au_result = stub_done ? stub_result : man_result;

  // AU stub answers lat_tab[op] cycles after au_start; monitor counts strobes
  initial begin
    stub_done = 1'b0; stub_result = '0; pend = 0; stab_err = 0;
    done_cnt = 0; start_cnt = 0; busy_cnt = 0;
    forever begin
      @(negedge clk);
      stub_done = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      if (done === 1'b1) done_cnt++;
      if (rst) begin
        pend = 0;
      end else if (pend > 0) begin
        if (au_R !== lr || au_S !== ls || au_Iimm !== li || au_op_sel !== lop) stab_err++;
        pend--;
        if (pend == 0) begin
          stub_done   = 1'b1;
          stub_result = au_func(lop, lr, ls, li);
        end
      end
      if (au_start === 1'b1) begin
        start_cnt++;
        iss_q.push_back('{r: au_R, s: au_S, i: au_Iimm, op: au_op_sel, ysel: au_mul_y_sel});
        if (stub_en && !rst) begin
          lr = au_R; ls = au_S; li = au_Iimm; lop = au_op_sel;
          pend = lat_tab[au_op_sel];
        end
      end
    end
  end

  // ---------------- reference register file and helpers ----------------
  logic [23:0] mrf [16];

  task automatic host_write(input logic [3:0] a, input logic [23:0] d);
    @(negedge clk);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    @(negedge clk);
    host_we = 1'b0;
    mrf[a] = d;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [23:0] d);
    host_addr = a;
    #1;
    d = host_rdata;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 16; i++) mrf[i] = '0;
  endtask

  task automatic clear_counts();
    done_cnt = 0; start_cnt = 0; busy_cnt = 0; stab_err = 0;
    iss_q.delete();
  endtask

  // Launch a program; optionally write r2 together with go, and poke go/host_we mid-run
  task automatic run_prog(input logic [7:0] start, input bit inject, input bit gowrite);
    int cyc;
    clear_counts();
    @(negedge clk);
    go = 1'b1; pc_start = start;
    if (gowrite) begin
      host_we = 1'b1; host_addr = 4'd2; host_wdata = 24'h00C000; mrf[2] = 24'h00C000;
    end
    cyc = 0;
    do begin
      @(negedge clk);
      go = 1'b0; host_we = 1'b0; cyc++;
      if (inject && cyc == 3) begin
        go = 1'b1; pc_start = 8'h40;
        host_we = 1'b1; host_addr = 4'd9; host_wdata = 24'h0ABCDE;
      end
    end while (busy === 1'b1 && cyc < 3000);
    go = 1'b0; host_we = 1'b0;
    check("prog_terminates", 32'(busy), 32'd0);
  endtask

  // Instruction-level reference execution of the program, then compare everything
  task automatic model_check(input logic [7:0] start, input string tag);
    logic [7:0]  pc;
    logic [20:0] ins;
    logic [23:0] r, s, i, v;
    int          n, exp_cyc, mism;
    pc = start; n = 0; exp_cyc = 2; mism = 0;
    ins = rom[pc];
    while (!ins[20] && n < 64) begin
      r = mrf[ins[11:8]]; s = mrf[ins[7:4]]; i = mrf[ins[3:0]];
      if (n < iss_q.size()) begin
        if (iss_q[n].r !== r || iss_q[n].s !== s || iss_q[n].i !== i ||
            iss_q[n].op !== ins[19:18] || iss_q[n].ysel !== ins[17:16]) mism++;
      end else begin
        mism++;
      end
      exp_cyc += 3 + lat_tab[ins[19:18]];
      mrf[ins[15:12]] = au_func(ins[19:18], r, s, i);
      pc = pc + 8'd1;
      n++;
      ins = rom[pc];
    end
    check({tag, "_issues"}, 32'(start_cnt), 32'(n));
    check({tag, "_operands"}, 32'(mism), 32'd0);
    check({tag, "_done_pulses"}, 32'(done_cnt), 32'd1);
    check({tag, "_busy_cycles"}, 32'(busy_cnt), 32'(exp_cyc));
    check({tag, "_stable"}, 32'(stab_err), 32'd0);
    for (int k = 0; k < 16; k++) begin
      read_reg(4'(k), v);
      check($sformatf("%s_r%0d", tag, k), 32'(v), 32'(mrf[k]));
    end
  endtask

  function automatic logic [23:0] rnd_sm();
    logic [23:0] v;
    v = 24'($urandom) & 24'h83FFFF;
    if ($urandom_range(0, 7) == 0) v = 24'h800000;
    return v;
  endfunction

  // ---------------- directed table ----------------
  typedef struct {
    string       name;
    logic [1:0]  op;
    logic [23:0] a, b, exp;
  } vec_t;

  vec_t vt [8];

  // Global watchdog so the run always ends
  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int          n, bad;
    logic [23:0] v;
    logic [7:0]  st, pcv;
    int          len;

    rst = 1'b1; go = 1'b0; pc_start = '0; host_we = 1'b0; host_addr = '0; host_wdata = '0;
    man_done = 1'b0; man_result = '0; stub_en = 1'b1;
    lat_tab[0] = 1; lat_tab[1] = 1; lat_tab[2] = 1; lat_tab[3] = 3;
    for (int k = 0; k < 256; k++) rom[k] = HALT;
    for (int k = 0; k < 16; k++) mrf[k] = '0;

    vt[0] = '{"add_2_3",   2'b00, 24'h008000, 24'h00C000, 24'h014000};
    vt[1] = '{"sub_2_3",   2'b01, 24'h008000, 24'h00C000, 24'h804000};
    vt[2] = '{"mul_2_3",   2'b10, 24'h008000, 24'h00C000, 24'h018000};
    vt[3] = '{"mul_m1_m1", 2'b10, 24'h804000, 24'h804000, 24'h004000};
    vt[4] = '{"add_m1_1",  2'b00, 24'h804000, 24'h004000, 24'h000000};
    vt[5] = '{"add_sat",   2'b00, 24'h7FFFFF, 24'h004000, 24'h7FFFFF};
    vt[6] = '{"sub_1_m2",  2'b01, 24'h004000, 24'h808000, 24'h00C000};
    vt[7] = '{"ext_2",     2'b11, 24'h008000, 24'h00C000, 24'h008000};

    // Reset state
    @(negedge clk);
    @(negedge clk);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    check("rst_au_start", 32'(au_start), 32'd0);
    check("rst_instr_addr", 32'(instr_addr), 32'd0);
    check("rst_operands", 32'(au_R | au_S | au_Iimm), 32'd0);
    check("rst_selects", 32'({au_op_sel, au_mul_y_sel}), 32'd0);
    rst = 1'b0;
    read_reg(4'd0, v);  check("rst_r0", 32'(v), 32'd0);
    read_reg(4'd15, v); check("rst_r15", 32'(v), 32'd0);

    // -0 is stored as a raw pattern
    host_write(4'd7, 24'h800000);
    read_reg(4'd7, v); check("neg_zero_kept", 32'(v), 32'h800000);

    // Table: single instruction + HALT
    for (int t = 0; t < 8; t++) begin
      host_write(4'd1, vt[t].a);
      host_write(4'd2, vt[t].b);
      rom[0] = enc(vt[t].op, 4'd3, 4'd1, 4'd2, 4'd0, 2'(t));
      rom[1] = HALT;
      run_prog(8'h00, 1'b0, 1'b0);
      model_check(8'h00, vt[t].name);
      read_reg(4'd3, v);
      check({vt[t].name, "_r3"}, 32'(v), 32'(vt[t].exp));
    end

    // Multi-instruction program using results of earlier ones
    host_write(4'd1, 24'h008000);
    host_write(4'd2, 24'h00C000);
    rom[8'h10] = enc(2'b01, 4'd4, 4'd1, 4'd2, 4'd0, 2'd0);
    rom[8'h11] = enc(2'b10, 4'd5, 4'd1, 4'd2, 4'd0, 2'd1);
    rom[8'h12] = enc(2'b10, 4'd6, 4'd4, 4'd4, 4'd0, 2'd2);
    rom[8'h13] = HALT;
    run_prog(8'h10, 1'b0, 1'b0);
    model_check(8'h10, "prog2");
    read_reg(4'd4, v); check("prog2_r4", 32'(v), 32'h804000);
    read_reg(4'd5, v); check("prog2_r5", 32'(v), 32'h018000);
    read_reg(4'd6, v); check("prog2_r6", 32'(v), 32'h004000);

    // Slow AU: 10-cycle latency, rf untouched and busy high until done
    do_reset();
    lat_tab[0] = 10;
    host_write(4'd1, 24'h008000);
    host_write(4'd2, 24'h00C000);
    host_write(4'd3, 24'h001234);
    rom[0] = enc(2'b00, 4'd3, 4'd1, 4'd2, 4'd0, 2'd0);
    rom[1] = HALT;
    clear_counts();
    host_addr = 4'd3;
    @(negedge clk); go = 1'b1; pc_start = 8'h00;
    @(negedge clk); go = 1'b0;
    n = 0;
    while (au_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    check("slow_issue_seen", 32'(au_start), 32'd1);
    n = 0; bad = 0;
    do begin
      @(negedge clk); #1;
      n++;
      if (busy !== 1'b1 || host_rdata !== 24'h001234) bad++;
    end while (au_done !== 1'b1 && n < 50);
    check("slow_done_latency", 32'(n), 32'd10);
    check("slow_hold", 32'(bad), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("slow_idle", 32'(busy), 32'd0);
    check("slow_one_start", 32'(start_cnt), 32'd1);
    check("slow_one_done", 32'(done_cnt), 32'd1);
    check("slow_stable", 32'(stab_err), 32'd0);
    read_reg(4'd3, v); check("slow_r3", 32'(v), 32'h014000);

    // Reset in WAIT, late au_done afterwards must be ignored
    stub_en = 1'b0;
    @(negedge clk); go = 1'b1; pc_start = 8'h00;
    @(negedge clk); go = 1'b0;
    n = 0;
    while (au_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    man_done = 1'b1; man_result = 24'h777777;
    #1;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_err", 32'(err), 32'd0);
    check("abort_au_start", 32'(au_start), 32'd0);
    check("abort_instr_addr", 32'(instr_addr), 32'd0);
    check("abort_operands", 32'(au_R | au_S | au_Iimm), 32'd0);
    check("abort_selects", 32'({au_op_sel, au_mul_y_sel}), 32'd0);
    @(negedge clk);
    man_done = 1'b0;
    bad = 0;
    for (int k = 0; k < 4; k++) begin @(negedge clk); if (busy !== 1'b0) bad++; end
    check("abort_stays_idle", 32'(bad), 32'd0);
    read_reg(4'd3, v); check("abort_r3", 32'(v), 32'd0);
    read_reg(4'd1, v); check("abort_r1", 32'(v), 32'd0);
    for (int k = 0; k < 16; k++) mrf[k] = '0;
    stub_en = 1'b1;

    // go/host_we while busy ignored, host write with go accepted, pc wraps 0xFF -> 0x00
    host_write(4'd1, 24'h008000);
    rom[8'hFF] = enc(2'b00, 4'd3, 4'd1, 4'd2, 4'd4, 2'd1);
    rom[8'h00] = HALT;
    rom[8'h40] = enc(2'b01, 4'd5, 4'd1, 4'd1, 4'd0, 2'd0);
    rom[8'h41] = HALT;
    run_prog(8'hFF, 1'b1, 1'b1);
    model_check(8'hFF, "wrap");
    read_reg(4'd3, v); check("wrap_r3", 32'(v), 32'h014000);
    read_reg(4'd9, v); check("wrap_r9_ignored", 32'(v), 32'd0);
    lat_tab[0] = 1;

`ifdef AU_TIMEOUT_EN
    // AU never answers: timeout after 255 WAIT cycles, then go clears err
    do_reset();
    stub_en = 1'b0;
    host_write(4'd3, 24'h000111);
    rom[0] = enc(2'b00, 4'd3, 4'd1, 4'd2, 4'd0, 2'd0);
    rom[1] = HALT;
    clear_counts();
    @(negedge clk); go = 1'b1; pc_start = 8'h00;
    @(negedge clk); go = 1'b0;
    n = 0;
    while (au_start !== 1'b1 && n < 10) begin @(negedge clk); n++; end
    n = 0;
    do begin
      @(negedge clk);
      if (busy === 1'b1) n++;
    end while (busy === 1'b1 && n < 400);
    check("tmo_wait_cycles", 32'(n), 32'd255);
    check("tmo_err", 32'(err), 32'd1);
    check("tmo_busy", 32'(busy), 32'd0);
    check("tmo_no_done", 32'(done_cnt), 32'd0);
    read_reg(4'd3, v); check("tmo_no_wb", 32'(v), 32'h000111);
    stub_en = 1'b1;
    rom[8'h20] = HALT;
    @(negedge clk); go = 1'b1; pc_start = 8'h20;
    @(negedge clk); go = 1'b0;
    check("tmo_err_cleared", 32'(err), 32'd0);
    n = 0;
    while (busy === 1'b1 && n < 20) begin @(negedge clk); n++; end
    check("tmo_recover_idle", 32'(busy), 32'd0);
`else
    // Without the timeout build WAIT holds forever and err stays low
    stub_en = 1'b0;
    rom[0] = enc(2'b00, 4'd3, 4'd1, 4'd2, 4'd0, 2'd0);
    rom[1] = HALT;
    @(negedge clk); go = 1'b1; pc_start = 8'h00;
    @(negedge clk); go = 1'b0;
    repeat (300) @(negedge clk);
    check("notmo_err", 32'(err), 32'd0);
    check("notmo_busy", 32'(busy), 32'd1);
    do_reset();
    check("notmo_reset_idle", 32'(busy), 32'd0);
    stub_en = 1'b1;
`endif

    // Randomized programs against the instruction-level reference
    for (int t = 0; t < 25; t++) begin
      do_reset();
      for (int k = 0; k < 4; k++) lat_tab[k] = $urandom_range(1, 4);
      for (int k = 0; k < 16; k++) host_write(4'(k), rnd_sm());
      st  = 8'($urandom);
      len = $urandom_range(1, 6);
      pcv = st;
      for (int j = 0; j < len; j++) begin
        rom[pcv] = enc(2'($urandom), 4'($urandom), 4'($urandom), 4'($urandom),
                       4'($urandom), 2'($urandom));
        pcv = pcv + 8'd1;
      end
      rom[pcv] = HALT;
      run_prog(st, 1'b0, 1'b0);
      model_check(st, $sformatf("rnd%0d", t));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
